// File: rtl/rs_age.sv
`default_nettype none
// ============================================================================
// Module   : rs_age
// Brief    : Unified reservation station, CDB wakeup, oldest-first issue per class
// Revision : 1.0 - initial release
// ============================================================================
module rs_age #(
    parameter int SIZE       = 16,
    parameter int DISPATCH_W = 3,
    parameter int CDB_W      = 3,
    parameter int NUM_PORTS  = 4,
    parameter int CLASS_W    = 2,
    parameter logic [NUM_PORTS*CLASS_W-1:0] PORT_CLASS = {2'd3, 2'd2, 2'd1, 2'd0},
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int ROBN_W     = 5,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  logic [DISPATCH_W-1:0]             disp_valid,
    input  logic [DISPATCH_W*CLASS_W-1:0]     disp_class,
    input  logic [DISPATCH_W-1:0]             disp_src1_ready,
    input  logic [DISPATCH_W-1:0]             disp_src2_ready,
    input  logic [DISPATCH_W*DATA_W-1:0]      disp_src1,
    input  logic [DISPATCH_W*DATA_W-1:0]      disp_src2,
    input  logic [DISPATCH_W*TAG_W-1:0]       disp_dest_tag,
    input  logic [DISPATCH_W*ROBN_W-1:0]      disp_robn,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0]   disp_payload,
    output logic                              disp_ready,
    input  logic [CDB_W-1:0]                  cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]            cdb_tag,
    input  logic [CDB_W*DATA_W-1:0]           cdb_value,
    output logic [NUM_PORTS-1:0]              iss_valid,
    input  logic [NUM_PORTS-1:0]              iss_ready,
    output logic [NUM_PORTS*DATA_W-1:0]       iss_op1,
    output logic [NUM_PORTS*DATA_W-1:0]       iss_op2,
    output logic [NUM_PORTS*TAG_W-1:0]        iss_dest_tag,
    output logic [NUM_PORTS*ROBN_W-1:0]       iss_robn,
    output logic [NUM_PORTS*PAYLOAD_W-1:0]    iss_payload,
    output logic [$clog2(SIZE+1)-1:0]         free_count
);

    localparam int c_IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int c_CNT_W = $clog2(SIZE + 1);

    // Entry storage; r_older[i][j] set means entry j is older than entry i.
    logic [SIZE-1:0]      r_valid, r_s1_rdy, r_s2_rdy;
    logic [CLASS_W-1:0]   r_class   [SIZE];
    logic [DATA_W-1:0]    r_src1    [SIZE];
    logic [DATA_W-1:0]    r_src2    [SIZE];
    logic [TAG_W-1:0]     r_dest    [SIZE];
    logic [ROBN_W-1:0]    r_robn    [SIZE];
    logic [PAYLOAD_W-1:0] r_payload [SIZE];
    logic [SIZE-1:0]      r_older   [SIZE];
    logic [c_CNT_W-1:0]   r_free_count;

    logic [NUM_PORTS-1:0]           r_iss_valid;
    logic [NUM_PORTS*DATA_W-1:0]    r_iss_op1, r_iss_op2;
    logic [NUM_PORTS*TAG_W-1:0]     r_iss_dest;
    logic [NUM_PORTS*ROBN_W-1:0]    r_iss_robn;
    logic [NUM_PORTS*PAYLOAD_W-1:0] r_iss_payload;

    function automatic logic [DATA_W:0] cdb_match(
        input logic [CDB_W-1:0]        vld,
        input logic [CDB_W*TAG_W-1:0]  tags,
        input logic [CDB_W*DATA_W-1:0] vals,
        input logic [TAG_W-1:0]        tag
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && (tag != '0) && (tags[c*TAG_W +: TAG_W] == tag))
                res = {1'b1, vals[c*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    logic w_accept;
    assign w_accept   = !reset && !squash && (r_free_count >= c_CNT_W'(DISPATCH_W));
    assign disp_ready = w_accept;

    // Wakeup of resident entries and of sources arriving on dispatch (bypass)
    logic [DATA_W:0]       w_em1 [SIZE];
    logic [DATA_W:0]       w_em2 [SIZE];
    logic [DATA_W:0]       w_dm1 [DISPATCH_W];
    logic [DATA_W:0]       w_dm2 [DISPATCH_W];
    logic [DISPATCH_W-1:0] w_d_rdy1, w_d_rdy2;
    logic [DATA_W-1:0]     w_d_val1 [DISPATCH_W];
    logic [DATA_W-1:0]     w_d_val2 [DISPATCH_W];

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            w_em1[i] = cdb_match(cdb_valid, cdb_tag, cdb_value, r_src1[i][TAG_W-1:0]);
            w_em2[i] = cdb_match(cdb_valid, cdb_tag, cdb_value, r_src2[i][TAG_W-1:0]);
        end
        for (int l = 0; l < DISPATCH_W; l++) begin
            w_dm1[l]    = cdb_match(cdb_valid, cdb_tag, cdb_value, disp_src1[l*DATA_W +: TAG_W]);
            w_dm2[l]    = cdb_match(cdb_valid, cdb_tag, cdb_value, disp_src2[l*DATA_W +: TAG_W]);
            w_d_rdy1[l] = disp_src1_ready[l] | w_dm1[l][DATA_W];
            w_d_rdy2[l] = disp_src2_ready[l] | w_dm2[l][DATA_W];
            w_d_val1[l] = (disp_src1_ready[l] || !w_dm1[l][DATA_W]) ?
                          disp_src1[l*DATA_W +: DATA_W] : w_dm1[l][DATA_W-1:0];
            w_d_val2[l] = (disp_src2_ready[l] || !w_dm2[l][DATA_W]) ?
                          disp_src2[l*DATA_W +: DATA_W] : w_dm2[l][DATA_W-1:0];
        end
    end

    // Allocation: each accepted lane takes the lowest free entry still unclaimed
    logic [SIZE-1:0]        w_free_vec, w_alloc_mask;
    logic [DISPATCH_W-1:0]  w_alloc_en;
    logic [c_IDX_W-1:0]     w_alloc_idx [DISPATCH_W];
    logic [SIZE-1:0]        w_alloc_row [DISPATCH_W];
    logic [c_CNT_W-1:0]     w_accept_cnt;
    logic                   w_found;

    always_comb begin
        w_free_vec   = ~r_valid;
        w_alloc_mask = '0;
        w_accept_cnt = '0;
        w_found      = 1'b0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            w_alloc_en[l]  = 1'b0;
            w_alloc_idx[l] = '0;
            w_alloc_row[l] = r_valid | w_alloc_mask;
            w_found        = 1'b0;
            if (w_accept && disp_valid[l]) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (!w_found && w_free_vec[i]) begin
                        w_found        = 1'b1;
                        w_alloc_idx[l] = c_IDX_W'(i);
                    end
                end
                if (w_found) begin
                    w_alloc_en[l]                = 1'b1;
                    w_free_vec[w_alloc_idx[l]]   = 1'b0;
                    w_alloc_mask[w_alloc_idx[l]] = 1'b1;
                    w_accept_cnt                 = w_accept_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // Select: ports in ascending order, each takes the oldest untaken eligible entry of its class
    logic [SIZE-1:0]      w_elig, w_taken, w_cand;
    logic [NUM_PORTS-1:0] w_port_free, w_gnt_en;
    logic [c_IDX_W-1:0]   w_gnt_idx [NUM_PORTS];
    logic [c_CNT_W-1:0]   w_gnt_cnt;

    always_comb begin
        w_elig    = r_valid & r_s1_rdy & r_s2_rdy;
        w_taken   = '0;
        w_cand    = '0;
        w_gnt_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_free[p] = !r_iss_valid[p] || iss_ready[p];
            w_gnt_en[p]    = 1'b0;
            w_gnt_idx[p]   = '0;
            for (int i = 0; i < SIZE; i++)
                w_cand[i] = w_elig[i] && !w_taken[i] &&
                            (r_class[i] == PORT_CLASS[p*CLASS_W +: CLASS_W]);
            if (w_port_free[p]) begin
                for (int i = 0; i < SIZE; i++) begin
                    if (w_cand[i] && ((r_older[i] & w_cand) == '0)) begin
                        w_gnt_en[p]  = 1'b1;
                        w_gnt_idx[p] = c_IDX_W'(i);
                    end
                end
            end
            if (w_gnt_en[p]) begin
                w_taken[w_gnt_idx[p]] = 1'b1;
                w_gnt_cnt             = w_gnt_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid       <= '0;
            r_s1_rdy      <= '0;
            r_s2_rdy      <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_class[i]   <= '0;
                r_src1[i]    <= '0;
                r_src2[i]    <= '0;
                r_dest[i]    <= '0;
                r_robn[i]    <= '0;
                r_payload[i] <= '0;
                r_older[i]   <= '0;
            end
            r_iss_valid   <= '0;
            r_iss_op1     <= '0;
            r_iss_op2     <= '0;
            r_iss_dest    <= '0;
            r_iss_robn    <= '0;
            r_iss_payload <= '0;
            r_free_count  <= c_CNT_W'(SIZE);
        end else if (squash) begin
            r_valid      <= '0;
            r_iss_valid  <= '0;
            r_free_count <= c_CNT_W'(SIZE);
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (r_valid[i] && !r_s1_rdy[i] && w_em1[i][DATA_W]) begin
                    r_s1_rdy[i] <= 1'b1;
                    r_src1[i]   <= w_em1[i][DATA_W-1:0];
                end
                if (r_valid[i] && !r_s2_rdy[i] && w_em2[i][DATA_W]) begin
                    r_s2_rdy[i] <= 1'b1;
                    r_src2[i]   <= w_em2[i][DATA_W-1:0];
                end
                r_older[i] <= r_older[i] & ~w_alloc_mask;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt_en[p])
                    r_valid[w_gnt_idx[p]] <= 1'b0;
                if (w_port_free[p]) begin
                    r_iss_valid[p] <= w_gnt_en[p];
                    if (w_gnt_en[p]) begin
                        r_iss_op1[p*DATA_W +: DATA_W]         <= r_src1[w_gnt_idx[p]];
                        r_iss_op2[p*DATA_W +: DATA_W]         <= r_src2[w_gnt_idx[p]];
                        r_iss_dest[p*TAG_W +: TAG_W]          <= r_dest[w_gnt_idx[p]];
                        r_iss_robn[p*ROBN_W +: ROBN_W]        <= r_robn[w_gnt_idx[p]];
                        r_iss_payload[p*PAYLOAD_W +: PAYLOAD_W] <= r_payload[w_gnt_idx[p]];
                    end
                end
            end
            for (int l = 0; l < DISPATCH_W; l++) begin
                if (w_alloc_en[l]) begin
                    r_valid[w_alloc_idx[l]]   <= 1'b1;
                    r_class[w_alloc_idx[l]]   <= disp_class[l*CLASS_W +: CLASS_W];
                    r_s1_rdy[w_alloc_idx[l]]  <= w_d_rdy1[l];
                    r_s2_rdy[w_alloc_idx[l]]  <= w_d_rdy2[l];
                    r_src1[w_alloc_idx[l]]    <= w_d_val1[l];
                    r_src2[w_alloc_idx[l]]    <= w_d_val2[l];
                    r_dest[w_alloc_idx[l]]    <= disp_dest_tag[l*TAG_W +: TAG_W];
                    r_robn[w_alloc_idx[l]]    <= disp_robn[l*ROBN_W +: ROBN_W];
                    r_payload[w_alloc_idx[l]] <= disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                    r_older[w_alloc_idx[l]]   <= w_alloc_row[l];
                end
            end
            r_free_count <= r_free_count - w_accept_cnt + w_gnt_cnt;
        end
    end

    assign iss_valid    = r_iss_valid;
    assign iss_op1      = r_iss_op1;
    assign iss_op2      = r_iss_op2;
    assign iss_dest_tag = r_iss_dest;
    assign iss_robn     = r_iss_robn;
    assign iss_payload  = r_iss_payload;
    assign free_count   = r_free_count;

endmodule
`default_nettype wire
